instr_fetch: RTL and testbench

//  Front-end fetch unit feeding the RV32 decoder: owns the PC, issues word reads to instruction

---
 rtl/instr_fetch_pkg.sv | 27 ++
 rtl/instr_fetch_if.sv | 35 +++
 rtl/instr_fetch_fifo.sv | 62 ++++++
 rtl/instr_fetch.sv | 122 ++++++++++++
 tb/tb_instr_fetch.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the RV32 instruction fetch front end.
//   XLEN / ILEN      : address and instruction widths
//   RESET_PC_DEFAULT : default PC of the first fetch after reset
//   fetch_state_e    : RUN (normal issue) / DRAIN (discarding wrong-path responses)
//   fetch_entry_t    : one buffered word together with its PC
//   align_pc()       : clears the byte-offset bits of a redirect target
package instr_fetch_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bundle of all handshake/bus signals around the fetch unit.
//   imem_req_*   : word read requests toward instruction memory (valid/ready)
//   imem_resp_*  : in-order read data, no backpressure
//   instr*       : fetched word + PC toward the decoder (valid/ready)
//   redirect_*   : taken branch/jump target from execute (1-cycle pulse)
//   misalign_err : 1-cycle pulse when a redirect target was not word aligned
// Modports: master = fetch unit, slave = its environment (memory/decoder/execute).
interface instr_fetch_if import instr_fetch_pkg::*; ;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [ILEN-1:0] imem_resp_data;
  logic            instr_valid;
  logic            instr_ready;
  logic [ILEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            misalign_err;

  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, misalign_err,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, instr_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, misalign_err,
    output imem_req_ready, imem_resp_valid, imem_resp_data, instr_ready,
           redirect_valid, redirect_pc
  );

endinterface

// File: rtl/instr_fetch_fifo.sv
// DEPTH-entry buffer of {pc, instr} words between memory responses and the decoder.
//   clk, rst   : clock, synchronous active-high reset (control state only)
//   push       : write push_data (allowed when full only together with a pop)
//   push_data  : {pc, instr} entry
//   pop        : drop the head entry (ignored when empty)
//   flush      : discard all entries, takes priority over push/pop
//   head       : oldest entry (undefined when empty)
//   count      : number of valid entries
//   empty/full : occupancy flags
module instr_fetch_fifo import instr_fetch_pkg::*; #(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            pop_eff;
  logic            push_eff;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign pop_eff  = pop && !empty;
  // A pop in the same cycle frees the slot the push needs.
  assign push_eff = push && (!full || pop_eff);
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_eff) wr_ptr <= wr_ptr + AW'(1);
      if (pop_eff)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push_eff, pop_eff})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_eff && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_fetch.sv
// RV32 instruction fetch unit: owns the PC, issues word reads to instruction memory,
// buffers returned words with their PC and hands them to the decoder.  Redirects from
// execute flush the buffer and discard responses that are still in flight.
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : instr_fetch_if.master (imem request/response, decoder output,
//          redirect input, misalign_err pulse)
// Parameters: RESET_PC (first fetch address), DEPTH (max outstanding + buffered words).
module instr_fetch import instr_fetch_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 2
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e    state;
  fetch_state_e    state_nxt;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] resp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   outstanding_nxt;
  logic [CW-1:0]   count;
  logic [CW:0]     in_use;
  logic            issue;
  logic            req_hs;
  logic            push;
  logic            pop;
  logic            empty;
  logic            full;
  logic            misalign_p1;
  fetch_entry_t    push_data;
  fetch_entry_t    head;

  // Credit: words in flight plus words buffered never exceed the buffer size, so
  // every response that returns in RUN is guaranteed a slot.
  assign in_use = {1'b0, outstanding} + {1'b0, count};
  assign issue  = !rst && (state == RUN) && !bus.redirect_valid
                  && (in_use < (CW+1)'(DEPTH));
  assign req_hs = issue && bus.imem_req_ready;

  assign bus.imem_req_valid = issue;
  assign bus.imem_req_addr  = pc;

  // Responses are accepted only on the current path; redirect cancels push and pop.
  assign push      = bus.imem_resp_valid && (state == RUN) && !bus.redirect_valid;
  assign pop       = bus.instr_valid && bus.instr_ready && !bus.redirect_valid;
  assign push_data = {resp_pc, bus.imem_resp_data};

  instr_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (bus.redirect_valid),
    .head      (head),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  // Data outputs are zeroed while empty so nothing stale leaks after reset/flush.
  assign bus.instr_valid  = !empty;
  assign bus.instr        = empty ? '0 : head.instr;
  assign bus.instr_pc     = empty ? '0 : head.pc;
  assign bus.misalign_err = misalign_p1;

  always_comb begin
    outstanding_nxt = outstanding;
    if (req_hs && !bus.imem_resp_valid)      outstanding_nxt = outstanding + CW'(1);
    else if (!req_hs && bus.imem_resp_valid) outstanding_nxt = outstanding - CW'(1);
  end

  // DRAIN holds until every wrong-path response has come back; the exit decision
  // uses the post-update count so RUN resumes in the first cycle with nothing in flight.
  always_comb begin
    state_nxt = state;
    if (bus.redirect_valid) begin
      state_nxt = (outstanding_nxt != '0) ? DRAIN : RUN;
    end else if ((state == DRAIN) && (outstanding_nxt == '0)) begin
      state_nxt = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      misalign_p1 <= 1'b0;
    end else begin
      outstanding <= outstanding_nxt;
      misalign_p1 <= bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
      if (bus.redirect_valid) begin
        pc      <= align_pc(bus.redirect_pc);
        resp_pc <= align_pc(bus.redirect_pc);
      end else begin
        if (req_hs) pc      <= pc + 32'd4;
        if (push)   resp_pc <= resp_pc + 32'd4;
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && full && !pop));

  a_addr_aligned: assert property (@(posedge clk) disable iff (rst)
    bus.imem_req_addr[1:0] == 2'b00);

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] due;
  } pend_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_if bus();

  instr_fetch #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t        exp_q[$];
  pend_t       pend[$];
  logic [31:0] acc_log[$];
  int          checks;
  int          errors;
  int          pushed_total;
  int          popped_total;
  int          n_acc;
  int          lat;
  logic [31:0] cyc;
  logic        sink_en;
  logic        force_ready;
  logic        mem_ready;

  assign bus.instr_ready    = force_ready || (sink_en && (pushed_total != popped_total));
  assign bus.imem_req_ready = mem_ready;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'hCAFE_0000;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({start + 32'(4 * i), mdata(start + 32'(4 * i))});
    end
    pushed_total += n;
  endtask

  task automatic wait_drained(input string name, input int limit);
    int k;
    k = 0;
    while ((popped_total != pushed_total) && (k < limit)) begin
      step();
      k++;
    end
    checks++;
    if (popped_total != pushed_total) begin
      errors++;
      $display("FAIL %s_timeout: consumed %0d required %0d", name, popped_total, pushed_total);
      exp_q.delete();
      popped_total = pushed_total;
    end
  endtask

  task automatic wait_acc(input string name, input int target, input int limit);
    int k;
    k = 0;
    while ((n_acc < target) && (k < limit)) begin
      step();
      k++;
    end
    checks++;
    if (n_acc < target) begin
      errors++;
      $display("FAIL %s_timeout: accepted %0d required %0d", name, n_acc, target);
    end
  endtask

  task automatic do_reset(input string name);
    rst = 1'b1;
    step();
    check32({name, "_req_valid"},   {31'b0, bus.imem_req_valid}, 32'h0);
    check32({name, "_instr_valid"}, {31'b0, bus.instr_valid},    32'h0);
    check32({name, "_instr"},       bus.instr,                   32'h0);
    check32({name, "_instr_pc"},    bus.instr_pc,                32'h0);
    check32({name, "_misalign"},    {31'b0, bus.misalign_err},   32'h0);
    check32({name, "_outstanding"}, 32'(dut.outstanding),        32'h0);
    step();
    rst = 1'b0;
  endtask

  // Instruction memory: in order, fixed latency `lat` cycles after the accepting edge.
  task automatic mem_model();
    pend_t p;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rst) begin
        pend.delete();
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
      end else if ((pend.size() > 0) && (pend[0].due <= cyc)) begin
        p = pend.pop_front();
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = mdata(p.addr);
      end else begin
        bus.imem_resp_valid = 1'b0;
      end
      @(negedge clk);
      if (!rst && bus.imem_req_valid && bus.imem_req_ready) begin
        pend.push_back({bus.imem_req_addr, cyc + 32'(lat)});
        acc_log.push_back(bus.imem_req_addr);
        n_acc++;
      end
    end
  endtask

  // Scoreboard monitor: every decoder-side transfer is compared with the queue head.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.imem_req_valid) begin
        check32("req_addr_align", {30'b0, bus.imem_req_addr[1:0]}, 32'h0);
      end
      if (!rst && bus.instr_valid && bus.instr_ready && !bus.redirect_valid) begin
        if (force_ready) begin
          check32("free_instr_data", bus.instr, mdata(bus.instr_pc));
        end else if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_instr: got pc %h, no word expected", bus.instr_pc);
        end else begin
          e = exp_q.pop_front();
          check32("instr_pc", bus.instr_pc, e.pc);
          check32("instr",    bus.instr,    e.data);
          @(posedge clk);
          #1;
          popped_total++;
        end
      end
    end
  endtask

  initial begin
    int base;
    int k;
    logic found;
    rst                 = 1'b1;
    sink_en             = 1'b0;
    force_ready         = 1'b0;
    mem_ready           = 1'b1;
    lat                 = 1;
    cyc                 = '0;
    checks              = 0;
    errors              = 0;
    pushed_total        = 0;
    popped_total        = 0;
    n_acc               = 0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;

    fork
      mem_model();
      monitor();
    join_none

    // 1: streaming from reset, 1-cycle memory, decoder always ready
    do_reset("t1_reset");
    sink_en = 1'b1;
    expect_seq(32'h0, 6);
    wait_drained("t1_stream", 60);

    // 2: decoder stalled -> only DEPTH requests, buffer holds 0 and 4
    sink_en = 1'b0;
    do_reset("t2_reset");
    base = n_acc;
    repeat (10) step();
    check32("t2_accepted",    32'(n_acc - base),           32'(DEPTH));
    check32("t2_req_valid",   {31'b0, bus.imem_req_valid}, 32'h0);
    check32("t2_instr_valid", {31'b0, bus.instr_valid},    32'h1);
    check32("t2_head_pc",     bus.instr_pc,                32'h0);
    sink_en = 1'b1;
    expect_seq(32'h0, 5);
    wait_drained("t2_release", 60);

    // 3: 3-cycle memory, redirect with two responses in flight
    sink_en = 1'b0;
    lat     = 3;
    do_reset("t3_reset");
    base = n_acc;
    wait_acc("t3_two_out", base + 2, 10);
    base = n_acc;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0100;
    #1;
    check32("t3_no_req_on_redirect", {31'b0, bus.imem_req_valid}, 32'h0);
    step();
    bus.redirect_valid = 1'b0;
    check32("t3_state_drain", 32'(dut.state), 32'(DRAIN));
    #1;
    check32("t3_no_req_in_drain", {31'b0, bus.imem_req_valid}, 32'h0);
    wait_acc("t3_refetch", base + 1, 20);
    if (n_acc > base) check32("t3_first_addr", acc_log[base], 32'h0000_0100);
    sink_en = 1'b1;
    expect_seq(32'h0000_0100, 3);
    wait_drained("t3_new_path", 80);

    // 4: misaligned redirect target
    base = n_acc;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0202;
    step();
    bus.redirect_valid = 1'b0;
    check32("t4_misalign_pulse", {31'b0, bus.misalign_err}, 32'h1);
    check32("t4_instr_valid",    {31'b0, bus.instr_valid},  32'h0);
    step();
    check32("t4_misalign_clear", {31'b0, bus.misalign_err}, 32'h0);
    wait_acc("t4_refetch", base + 1, 20);
    if (n_acc > base) check32("t4_first_addr", acc_log[base], 32'h0000_0200);
    expect_seq(32'h0000_0200, 3);
    wait_drained("t4_new_path", 80);

    // 5: redirect coinciding with a response and a decoder pop
    repeat (8) step();
    lat         = 1;
    force_ready = 1'b1;
    found       = 1'b0;
    k           = 0;
    while (!found && (k < 40)) begin
      step();
      k++;
      if (bus.imem_resp_valid && bus.instr_valid) found = 1'b1;
    end
    check32("t5_collision_found", {31'b0, found}, 32'h1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0300;
    step();
    bus.redirect_valid = 1'b0;
    force_ready        = 1'b0;
    check32("t5_instr_valid", {31'b0, bus.instr_valid}, 32'h0);
    check32("t5_outstanding", 32'(dut.outstanding),     32'h0);
    check32("t5_state_run",   32'(dut.state),           32'(RUN));
    expect_seq(32'h0000_0300, 3);
    wait_drained("t5_new_path", 60);

    // 6: reset with two requests in flight
    lat  = 3;
    base = n_acc;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0400;
    step();
    bus.redirect_valid = 1'b0;
    wait_acc("t6_two_out", base + 2, 10);
    if (n_acc > base) check32("t6_first_addr", acc_log[base], 32'h0000_0400);
    do_reset("t6_reset");
    expect_seq(RPC, 4);
    wait_drained("t6_restart", 80);

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
